// File: rtl/vsm_pc_sequencer.sv
// Fetch/execute control FSM for the VSM core; sole owner of PC increment/load/clear.
// Optional macro VSM_SINGLE_STEP_EN adds a Step input and parks in IDLE after each instruction.
module vsm_pc_sequencer #(
  parameter int unsigned PC_W        = 4,
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic             MainClock,
  input  logic             ClearCounter,
  input  logic             Run,
`ifdef VSM_SINGLE_STEP_EN
  input  logic             Step,
`endif
  input  logic [OPC_W-1:0] Opcode,
  input  logic [PC_W-1:0]  Operand,
  input  logic             MemReady,
  input  logic             Zero,
  output logic             MemRead,
  output logic             IrLoad,
  output logic             ExecEn,
  output logic             EnableCount,
  output logic             LoadPC,
  output logic [PC_W-1:0]  PCTarget,
  output logic             ClearPC,
  output logic             Halted,
  output logic [1:0]       Phase
);

  localparam int unsigned      CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_JZ    = OPC_W'(13);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  state_e            state_q, state_d, next_instr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OPC_W-1:0]  op_q, op_d;
  logic [PC_W-1:0]   arg_q, arg_d;
  logic              run_q, clear_pc_q;
  logic              run_rise, step_rise;
  logic              mem_read_c, ir_load_c, exec_en_c, en_count_c, load_pc_c, halted_c;

  assign run_rise = Run & ~run_q;

`ifdef VSM_SINGLE_STEP_EN
  logic step_q;

  assign step_rise  = Step & ~step_q;
  assign next_instr = S_IDLE;

  always_ff @(posedge MainClock) begin
    if (ClearCounter) step_q <= 1'b0;
    else              step_q <= Step;
  end
`else
  assign step_rise  = 1'b0;
  assign next_instr = S_FETCH;
`endif

  // Next-state and decoded outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    arg_d      = arg_q;
    mem_read_c = 1'b0;
    ir_load_c  = 1'b0;
    exec_en_c  = 1'b0;
    en_count_c = 1'b0;
    load_pc_c  = 1'b0;
    halted_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_rise || step_rise) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (MemReady) begin
          ir_load_c = 1'b1;
          op_d      = Opcode;
          arg_d     = Operand;
          cnt_d     = CNT_LOAD;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_en_c = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = next_instr;
          case (op_q)
            OP_HALT: state_d   = S_HALT;
            OP_JMP:  load_pc_c = 1'b1;
            OP_JZ: begin
              load_pc_c  = Zero;
              en_count_c = ~Zero;
            end
            default: en_count_c = 1'b1;
          endcase
        end
      end
      S_HALT: begin
        halted_c = 1'b1;
        if (run_rise) begin
          en_count_c = 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // An aborted fetch/exec must never move the PC
    if (ClearCounter) begin
      ir_load_c  = 1'b0;
      en_count_c = 1'b0;
      load_pc_c  = 1'b0;
    end
  end

  always_ff @(posedge MainClock) begin
    if (ClearCounter) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      arg_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      run_q   <= Run;
    end
  end

  always_ff @(posedge MainClock) begin
    clear_pc_q <= ClearCounter;
  end

  assign MemRead     = mem_read_c;
  assign IrLoad      = ir_load_c;
  assign ExecEn      = exec_en_c;
  assign EnableCount = en_count_c;
  assign LoadPC      = load_pc_c;
  assign PCTarget    = load_pc_c ? arg_q : '0;
  assign ClearPC     = clear_pc_q;
  assign Halted      = halted_c;
  assign Phase       = state_q;

endmodule
